dpram_loader: RTL
=================

Name: dpram_loader

Overview:
Writer-side engine for the dual-port RAM write port (we/waddr/wdata, with registered readback on doutb). Accepts 32-bit words from the bridge/data-loader stream over a valid/ready handshake. Serialises each word big-endian into bytes and writes them to consecutive RAM addresses from BASE_ADDR. Optionally reads back each byte to verify it, and reports busy/done/error to the core's host logic.

Parameters:
ADDR_WIDTH, 16, RAM address width; must match the target RAM.
DATA_WIDTH, 8, RAM data width; fixed at 8, any other value is unsupported.
BASE_ADDR, 0, first RAM address written after start.
VERIFY, 1, 1 = write-then-readback check per byte; 0 = write only.

Ports:
clk  in  1  system clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse; latches length and begins a load.
length  in  ADDR_WIDTH+1  number of bytes to load, 0..2^ADDR_WIDTH; sampled on start.
in_valid  in  1  input word valid.
in_data  in  32  input word; byte 0 = in_data[31:24].
in_ready  out  1  loader can accept a word this cycle.
we  out  1  RAM write enable.
waddr  out  ADDR_WIDTH  RAM write/readback address.
wdata  out  8  RAM write data.
doutb  in  8  RAM readback; registered copy of memory[waddr], one-cycle latency.
busy  out  1  load in progress.
done  out  1  sticky; set when the load completes, cleared by start or reset.
error  out  1  sticky; set on the first verify mismatch.
err_addr  out  ADDR_WIDTH  address of the first mismatch.
byte_count  out  ADDR_WIDTH+1  bytes written so far in the current load.

Behaviour:
- Outputs: all registered. Reset forces IDLE and drives in_ready, we, busy, done and error to 0. waddr, wdata, err_addr and byte_count reset to 0.
- States: IDLE, WAIT_WORD, WRITE, VRD, VCHK, DONE.
- IDLE:
  - start with length=0 -> DONE.
  - start with length>0 -> WAIT_WORD. On that same edge: addr=BASE_ADDR, byte_count=0, remaining=length, done=0, error=0, err_addr=0.
- WAIT_WORD:
  - in_ready=1 only in this state.
  - A word transfers when in_valid&in_ready. On transfer: latch the word, lane=0, go to WRITE.
  - in_valid is ignored in every other state.
- WRITE (one cycle):
  - we=1, waddr=addr, wdata=word lane (lane 0 = bits 31:24).
  - byte_count increments and remaining decrements on the exit edge.
  - VERIFY=1 -> VRD. VERIFY=0 -> byte advance.
- VRD (one cycle): we=0, waddr=addr held. doutb becomes valid at the end of this cycle.
- VCHK (one cycle):
  - On doutb != written byte with error=0: set error=1, err_addr=addr.
  - Later mismatches do not overwrite err_addr. The load continues after any mismatch.
  - Exit -> byte advance.
- Byte advance:
  - addr increments, wrapping modulo 2^ADDR_WIDTH; no stall or flag on wrap.
  - remaining=0 -> DONE. Unused lanes of the final word are discarded.
  - Else lane<3 -> lane+1, go to WRITE.
  - Else (lane=3) -> WAIT_WORD.
- Throughput: VERIFY=0 gives 1 cycle per byte, plus at least 1 cycle per word in WAIT_WORD. VERIFY=1 gives 3 cycles per byte.
- busy=1 in WAIT_WORD, WRITE, VRD and VCHK.
- DONE:
  - done=1 and busy=0; remain in DONE until start.
  - start in DONE behaves as start in IDLE.
- Simultaneous events:
  - start while busy aborts the current load and restarts with the new length on that edge.
  - start coinciding with an accepted word drops that word.
  - reset has priority over start and over an in-flight write. we is 0 on the cycle after reset is sampled.
- Pipeline invariant: we is never asserted in two consecutive cycles when VERIFY=1.

Test Plan:
- Basic load, VERIFY=0, BASE_ADDR=0x100: start with length=8, words 0x11223344 and 0x55667788 -> RAM 0x100..0x107 = 11 22 33 44 55 66 77 88; done=1; byte_count=8; exactly 8 we pulses.
- Partial word, VERIFY=0: length=5, words 0xAABBCCDD and 0xEEFF0011 -> only 0x100..0x104 written (AA BB CC DD EE); in_ready low after the 2nd word; 0x105 unchanged.
- Backpressure: in_valid held low 10 cycles mid-load, then toggled every other cycle -> in_ready only in WAIT_WORD, no word lost or duplicated, final RAM contents correct.
- Verify fault: VERIFY=1, bench model corrupts doutb on the readback of address 0x102, then again at 0x105 -> error=1, err_addr=0x102, load still completes, done=1, 3-cycle byte spacing observed.
- Wrap and zero length: ADDR_WIDTH=4, BASE_ADDR=0xE, length=4, word 0x01020304 -> RAM[0xE]=01, [0xF]=02, [0x0]=03, [0x1]=04; then start with length=0 -> done=1 the next cycle, no we pulses.
- Reset mid-load: assert reset during WRITE of the 3rd byte -> we=0 on the next cycle, busy=0, done=0, byte_count=0; a new start then loads from BASE_ADDR correctly.

Source files
------------

// File: rtl/dpram_loader.sv
// Streams 32-bit words into a byte-wide dual-port RAM, big-endian, from BASE_ADDR,
// with an optional per-byte write/readback/compare sequence.
module dpram_loader #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    VERIFY     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  in_valid,
  input  logic [31:0]           in_data,
  output logic                  in_ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] doutb,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [ADDR_WIDTH:0]   byte_count
);

  typedef enum logic [2:0] {IDLE, WAIT_WORD, WRITE, VRD, VCHK, DONE} state_t;

  localparam logic [ADDR_WIDTH:0]   ONE_CNT  = 1;
  localparam logic [ADDR_WIDTH-1:0] ONE_ADDR = 1;

  state_t                state, state_nxt, adv_state;
  logic [31:0]           word;
  logic [1:0]            lane;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  last;
  logic                  advance;
  logic                  xfer;

  // The current byte is always the top lane of the shifted word register.
  assign wdata   = word[31 -: DATA_WIDTH];
  assign xfer    = in_valid && in_ready;
  assign advance = (state == WRITE && VERIFY == 0) || state == VCHK;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    adv_state = WRITE;
    // In WRITE the decrement has not landed yet, so the final byte shows remaining==1.
    last = (state == WRITE) ? (remaining == ONE_CNT) : (remaining == '0);
    if (last)              adv_state = DONE;
    else if (lane == 2'd3) adv_state = WAIT_WORD;
    if (start) begin
      state_nxt = (length == '0) ? DONE : WAIT_WORD;
    end else begin
      case (state)
        WAIT_WORD: if (xfer) state_nxt = WRITE;
        WRITE:     state_nxt = (VERIFY != 0) ? VRD : adv_state;
        VRD:       state_nxt = VCHK;
        VCHK:      state_nxt = adv_state;
        default:   state_nxt = state;
      endcase
    end
  end

  // Registered outputs follow the state being entered so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready   <= 1'b0;
      we         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_addr   <= '0;
      byte_count <= '0;
      waddr      <= '0;
      word       <= '0;
      lane       <= '0;
      remaining  <= '0;
    end else begin
      in_ready <= (state_nxt == WAIT_WORD);
      we       <= (state_nxt == WRITE);
      busy     <= (state_nxt == WAIT_WORD) || (state_nxt == WRITE) ||
                  (state_nxt == VRD) || (state_nxt == VCHK);
      done     <= (state_nxt == DONE);
      if (start) begin
        waddr      <= BASE_ADDR;
        byte_count <= '0;
        remaining  <= length;
        error      <= 1'b0;
        err_addr   <= '0;
      end else begin
        if (xfer) begin
          word <= in_data;
          lane <= 2'd0;
        end
        if (state == WRITE) begin
          byte_count <= byte_count + ONE_CNT;
          remaining  <= remaining - ONE_CNT;
        end
        if (state == VCHK && doutb != wdata && !error) begin
          error    <= 1'b1;
          err_addr <= waddr;
        end
        if (advance) begin
          waddr <= waddr + ONE_ADDR;
          lane  <= lane + 2'd1;
          word  <= {word[31-DATA_WIDTH:0], {DATA_WIDTH{1'b0}}};
        end
      end
    end
  end

endmodule
